issue_buffer: RTL
=================

Name: issue_buffer

Overview:
- Dual-issue instruction buffer and issue arbiter between decode and the EX pipeline register.
- Queues up to DEPTH decoded instructions and presents the two oldest to the score board through its 4 read ports.
- Issues 0, 1 or 2 instructions per cycle with per-operand bypass selects.
- Drives the score board write ports for every issued destination register.

Parameters:
- DEPTH, 8, FIFO entries (power of two, >=4).
- PAYLOAD_W, 64, opaque decoded-instruction payload width forwarded untouched.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  downstream stall; nothing issues this cycle.
- flash  in  1  pipeline flush; empties buffer.
- in_valid  in  2  decode slots valid; in_valid[1] only legal with in_valid[0].
- in_payload  in  2xPAYLOAD_W  decoded payloads.
- in_rs, in_rt, in_rd  in  2x5 each  register addresses.
- in_rs_used, in_rt_used, in_rd_wr  in  2 each  source used / dest written.
- in_is_mem, in_is_load, in_is_branch  in  2 each  class flags.
- in_ready  out  1  free entries >= 2.
- sb_read_addr  out  4x5  {slot1.rt, slot1.rs, slot0.rt, slot0.rs}, combinational from the two head entries.
- sb_data  in  4x4  score board entries {load, position[2:0]}; position[2]=EX, [1]=MEM, [0]=WB.
- sb_write_ena  out  2  per-slot score board write.
- sb_write_addr  out  2x5  destination register.
- sb_data_in  out  2x4  {is_load, 3'b100}.
- out_valid  out  2  registered issue valids.
- out_payload  out  2xPAYLOAD_W  registered payloads.
- out_byp_rs, out_byp_rt  out  2x2 each  registered bypass select: 00 regfile, 01 EX, 10 MEM, 11 WB.

Behaviour:
- Reset (rst=1 at posedge) or flash=1:
  - head=tail=count=0.
  - out_valid=0, out_payload=0, out_byp_*=0, sb_write_ena=0.
  - Inputs that cycle are dropped.
  - in_ready=1 from the first cycle after.
- Enqueue:
  - When in_ready && in_valid[0]: write slot0 at tail, then slot1 if in_valid[1].
  - tail advances by popcount(in_valid), wrapping mod DEPTH.
  - in_valid while !in_ready is ignored (decode holds).
- Source hazard per operand, checked only if the operand is used and its address != 0:
  - position==0 -> no hazard, bypass 00.
  - position[2] && load -> hazard.
  - position[2] && !load -> bypass 01.
  - position[1] -> bypass 10.
  - position[0] -> bypass 11.
  - Higher bit wins if more than one bit is set.
- Slot0 issues iff count>=1, !stall, and no slot0 source hazard.
- Slot1 issues iff slot0 issues, count>=2, no slot1 source hazard, and all of:
  - no dependency on slot0: slot0.rd_wr && slot0.rd!=0 && slot0.rd equals a used slot1 source;
  - not (both is_mem);
  - slot1 not is_branch.
- Issue strictly in order; slot1 never issues alone.
- Score board write, same cycle as the issue decision (combinational):
  - sb_write_ena[k] = issued[k] && rd_wr[k] && rd[k]!=0.
  - When both slots write the same rd, both enables stay asserted; the score board lets slot1 win.
- Output register: next cycle out_valid=issued, with payload and bypass selects captured. During stall, out_valid is cleared (bubble inserted).
- Dequeue: head advances by popcount(issued).
- count next = count + enqueued - issued. Simultaneous enqueue and dequeue are legal.
- count never exceeds DEPTH; that is guaranteed by in_ready.
- Latency: an instruction enqueued in cycle N is examined in N+1 and appears on out_* at N+2 at the earliest.

Test Plan:
1. Enqueue 2 independent ALU ops (rd=3,rd=4, sources r1,r2) with all score board entries 0 -> sb_write_ena=11, data_in=4'b0100; next cycle out_valid=11, bypass all 00.
2. Slot0 reads r5 with sb_data={1,100} (load in EX) -> out_valid=00, no writes. Next cycle the score board returns {1,010} -> slot0 issues with out_byp_rs[0]=10.
3. Slot0 writes r7, slot1 reads r7 -> slot0 issues alone; slot1 issues the following cycle with bypass 01 when the score board shows {0,100}.
4. Two loads at head -> single issue per cycle. Slot1 branch -> not paired. Both rd=9 -> sb_write_ena=11, sb_write_addr=9,9.
5. Fill to DEPTH with stall=1 -> in_ready drops at count=DEPTH-1. Drop stall -> count drains by 2/cycle, wrap correct, in_ready rises.
6. flash asserted with count=5 and in_valid=11 -> next cycle count=0, out_valid=00, in_ready=1. Repeat with rst mid-stream -> same.

Source files
------------

// File: rtl/issue_buffer.sv
// Dual-issue instruction buffer: queues decoded instructions and, each cycle,
// issues up to the two oldest to EX with score-board-driven hazard/bypass checks.
module issue_buffer #(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flash,
  input  logic [1:0]             in_valid,
  input  logic [2*PAYLOAD_W-1:0] in_payload,
  input  logic [9:0]             in_rs,
  input  logic [9:0]             in_rt,
  input  logic [9:0]             in_rd,
  input  logic [1:0]             in_rs_used,
  input  logic [1:0]             in_rt_used,
  input  logic [1:0]             in_rd_wr,
  input  logic [1:0]             in_is_mem,
  input  logic [1:0]             in_is_load,
  input  logic [1:0]             in_is_branch,
  output logic                   in_ready,
  output logic [19:0]            sb_read_addr,
  input  logic [15:0]            sb_data,
  output logic [1:0]             sb_write_ena,
  output logic [9:0]             sb_write_addr,
  output logic [7:0]             sb_data_in,
  output logic [1:0]             out_valid,
  output logic [2*PAYLOAD_W-1:0] out_payload,
  output logic [3:0]             out_byp_rs,
  output logic [3:0]             out_byp_rt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [4:0]           rd;
    logic                 rs_used;
    logic                 rt_used;
    logic                 rd_wr;
    logic                 is_mem;
    logic                 is_load;
    logic                 is_branch;
  } entry_t;

  // Returns {hazard, bypass[1:0]}; the highest set position bit decides.
  function automatic logic [2:0] check_src(input logic used, input logic [4:0] addr,
                                           input logic [3:0] sb);
    logic [2:0] res;
    res = 3'b000;
    if (used && addr != 5'd0) begin
      if (sb[2])      res = sb[3] ? 3'b100 : 3'b001;
      else if (sb[1]) res = 3'b010;
      else if (sb[0]) res = 3'b011;
    end
    return res;
  endfunction

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  entry_t        w_in [2];
  entry_t        w_e0;
  entry_t        w_e1;
  logic [2:0]    w_chk [4];
  logic          w_kill;
  logic          w_enq;
  logic          w_dep;
  logic          w_iss0;
  logic          w_iss1;
  logic [CW-1:0] w_n_enq;
  logic [CW-1:0] w_n_iss;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_in[k].payload   = in_payload[k*PAYLOAD_W +: PAYLOAD_W];
      w_in[k].rs        = in_rs[k*5 +: 5];
      w_in[k].rt        = in_rt[k*5 +: 5];
      w_in[k].rd        = in_rd[k*5 +: 5];
      w_in[k].rs_used   = in_rs_used[k];
      w_in[k].rt_used   = in_rt_used[k];
      w_in[k].rd_wr     = in_rd_wr[k];
      w_in[k].is_mem    = in_is_mem[k];
      w_in[k].is_load   = in_is_load[k];
      w_in[k].is_branch = in_is_branch[k];
    end
  end

  assign w_e0   = r_mem[r_head];
  assign w_e1   = r_mem[r_head + AW'(1)];
  assign w_kill = rst | flash;

  assign in_ready     = (CW'(DEPTH) - r_count) >= CW'(2);
  assign sb_read_addr = {w_e1.rt, w_e1.rs, w_e0.rt, w_e0.rs};

  assign w_chk[0] = check_src(w_e0.rs_used, w_e0.rs, sb_data[3:0]);
  assign w_chk[1] = check_src(w_e0.rt_used, w_e0.rt, sb_data[7:4]);
  assign w_chk[2] = check_src(w_e1.rs_used, w_e1.rs, sb_data[11:8]);
  assign w_chk[3] = check_src(w_e1.rt_used, w_e1.rt, sb_data[15:12]);

  // RAW between the pair cannot be bypassed in the same cycle, so slot1 waits.
  assign w_dep = w_e0.rd_wr && (w_e0.rd != 5'd0) &&
                 ((w_e1.rs_used && w_e1.rs == w_e0.rd) || (w_e1.rt_used && w_e1.rt == w_e0.rd));

  assign w_iss0 = !w_kill && (r_count != '0) && !stall && !w_chk[0][2] && !w_chk[1][2];
  assign w_iss1 = w_iss0 && (r_count >= CW'(2)) && !w_chk[2][2] && !w_chk[3][2] && !w_dep &&
                  !(w_e0.is_mem && w_e1.is_mem) && !w_e1.is_branch;

  assign w_enq   = !w_kill && in_ready && in_valid[0];
  assign w_n_enq = !w_enq ? CW'(0) : (in_valid[1] ? CW'(2) : CW'(1));
  assign w_n_iss = w_iss1 ? CW'(2) : (w_iss0 ? CW'(1) : CW'(0));

  assign sb_write_ena[0] = w_iss0 && w_e0.rd_wr && (w_e0.rd != 5'd0);
  assign sb_write_ena[1] = w_iss1 && w_e1.rd_wr && (w_e1.rd != 5'd0);
  assign sb_write_addr   = {w_e1.rd, w_e0.rd};
  assign sb_data_in      = {w_e1.is_load, 3'b100, w_e0.is_load, 3'b100};

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_tail] <= w_in[0];
      if (in_valid[1]) r_mem[r_tail + AW'(1)] <= w_in[1];
    end
  end

  // Issue boundary: decision registered into the EX pipeline register.
  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      out_valid   <= 2'b00;
      out_payload <= '0;
      out_byp_rs  <= 4'b0000;
      out_byp_rt  <= 4'b0000;
    end else begin
      r_head    <= r_head + AW'(w_n_iss);
      r_tail    <= r_tail + AW'(w_n_enq);
      r_count   <= r_count + w_n_enq - w_n_iss;
      out_valid <= {w_iss1, w_iss0};
      if (w_iss0) begin
        out_payload[PAYLOAD_W-1:0] <= w_e0.payload;
        out_byp_rs[1:0]            <= w_chk[0][1:0];
        out_byp_rt[1:0]            <= w_chk[1][1:0];
      end
      if (w_iss1) begin
        out_payload[2*PAYLOAD_W-1:PAYLOAD_W] <= w_e1.payload;
        out_byp_rs[3:2]                      <= w_chk[2][1:0];
        out_byp_rt[3:2]                      <= w_chk[3][1:0];
      end
    end
  end
endmodule
